// File: rtl/monitor_bus_master.sv
// BKM-68X option-slot bus initiator: turns single-byte host requests into slot bus cycles.
// Define MONBUS_IRQ_SYNC_EN to pass irq_x through a 2-flop synchronizer with edge detect.
module monitor_bus_master #(
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned STROBE_CYCLES = 10,
    parameter int unsigned HOLD_CYCLES   = 2,
    parameter int unsigned RESET_CYCLES  = 16
) (
    input  logic       clk_50mhz_in,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    input  logic       bus_reset_req,
    output logic       irq_pending,
    output logic       irq_edge,
    output logic       slot_x_int_x,
    output logic       clk_rw,
    output logic       ax_d,
    output logic       r_wx,
    output logic       reset_x,
    output logic [7:0] ad_out,
    output logic       ad_oe_x,
    input  logic [7:0] ad_in,
    input  logic       irq_x
);

    typedef enum logic [2:0] {
        RST, IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD
    } state_t;

    state_t      state, nxt;
    logic [15:0] cnt;
    logic        wr_q;
    logic [7:0]  addr_q, wdata_q;
    logic        accept;
    logic        cur_write;
    logic [7:0]  cur_addr, cur_wdata;
    logic        a_ph, d_ph;

    assign req_ready = (state == IDLE);

    always_comb begin
        accept    = (state == IDLE) && req_valid && !bus_reset_req;
        cur_write = accept ? req_write : wr_q;
        cur_addr  = accept ? req_addr  : addr_q;
        cur_wdata = accept ? req_wdata : wdata_q;
        nxt       = state;
        unique case (state)
            RST:      if (cnt == 16'(RESET_CYCLES))      nxt = IDLE;
            IDLE:     if (bus_reset_req)                 nxt = RST;
                      else if (req_valid)                nxt = A_SETUP;
            A_SETUP:  if (cnt == 16'(SETUP_CYCLES - 1))  nxt = A_STROBE;
            A_STROBE: if (cnt == 16'(STROBE_CYCLES - 1)) nxt = A_HOLD;
            A_HOLD:   if (cnt == 16'(HOLD_CYCLES - 1))   nxt = D_SETUP;
            D_SETUP:  if (cnt == 16'(SETUP_CYCLES - 1))  nxt = D_STROBE;
            D_STROBE: if (cnt == 16'(STROBE_CYCLES - 1)) nxt = D_HOLD;
            D_HOLD:   if (cnt == 16'(HOLD_CYCLES - 1))   nxt = IDLE;
        endcase
        a_ph = (nxt == A_SETUP) || (nxt == A_STROBE) || (nxt == A_HOLD);
        d_ph = (nxt == D_SETUP) || (nxt == D_STROBE) || (nxt == D_HOLD);
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk_50mhz_in) begin
        if (reset) begin
            state        <= RST;
            cnt          <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            reset_x      <= 1'b0;
            slot_x_int_x <= 1'b1;
            clk_rw       <= 1'b1;
            ax_d         <= 1'b1;
            r_wx         <= 1'b1;
            ad_oe_x      <= 1'b1;
            ad_out       <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
        end else begin
            state <= nxt;
            // RST counts from 1 on entry so the first reset-low edge and a bus reset request both give RESET_CYCLES low cycles.
            if (nxt == RST && state != RST)
                cnt <= 16'd1;
            else if (nxt != state || state == IDLE)
                cnt <= '0;
            else
                cnt <= cnt + 16'd1;

            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end

            reset_x      <= (nxt != RST);
            slot_x_int_x <= !(a_ph || d_ph);
            clk_rw       <= !(nxt == A_STROBE || nxt == D_STROBE);
            ax_d         <= !a_ph;
            r_wx         <= (a_ph || d_ph) ? !cur_write : 1'b1;
            if (a_ph) begin
                ad_oe_x <= 1'b0;
                ad_out  <= cur_addr;
            end else if (d_ph && cur_write) begin
                ad_oe_x <= 1'b0;
                ad_out  <= cur_wdata;
            end else begin
                ad_oe_x <= 1'b1;
                ad_out  <= '0;
            end

            rsp_valid <= (state == D_HOLD) && (nxt == IDLE);
            if (state == D_STROBE && nxt == D_HOLD && !wr_q)
                rsp_rdata <= ad_in;
        end
    end

`ifdef MONBUS_IRQ_SYNC_EN
    logic irq_s1, irq_s2, irq_s3;

    always_ff @(posedge clk_50mhz_in) begin
        if (reset) begin
            irq_s1 <= 1'b1;
            irq_s2 <= 1'b1;
            irq_s3 <= 1'b1;
        end else begin
            irq_s1 <= irq_x;
            irq_s2 <= irq_s1;
            irq_s3 <= irq_s2;
        end
    end

    assign irq_pending = !irq_s2;
    assign irq_edge    = irq_s3 && !irq_s2;
`else
    always_ff @(posedge clk_50mhz_in) begin
        if (reset)
            irq_pending <= 1'b0;
        else
            irq_pending <= !irq_x;
    end

    assign irq_edge = 1'b0;
`endif

endmodule

// File: tb/tb_monitor_bus_master.sv
// Directed bench for monitor_bus_master: transaction table plus reset, back-to-back, irq and bus-reset sequences.
module tb_monitor_bus_master;

    logic       clk = 1'b0;
    logic       reset, req_valid, req_write, bus_reset_req, irq_x;
    logic [7:0] req_addr, req_wdata, ad_in;
    logic       req_ready, rsp_valid, irq_pending, irq_edge;
    logic       slot_x_int_x, clk_rw, ax_d, r_wx, reset_x, ad_oe_x;
    logic [7:0] rsp_rdata, ad_out;

`ifdef MONBUS_IRQ_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] card;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[4];

    always #10 clk = ~clk;

    monitor_bus_master #(
        .SETUP_CYCLES (2),
        .STROBE_CYCLES(10),
        .HOLD_CYCLES  (2),
        .RESET_CYCLES (16)
    ) dut (
        .clk_50mhz_in (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .bus_reset_req(bus_reset_req),
        .irq_pending  (irq_pending),
        .irq_edge     (irq_edge),
        .slot_x_int_x (slot_x_int_x),
        .clk_rw       (clk_rw),
        .ax_d         (ax_d),
        .r_wx         (r_wx),
        .reset_x      (reset_x),
        .ad_out       (ad_out),
        .ad_oe_x      (ad_oe_x),
        .ad_in        (ad_in),
        .irq_x        (irq_x)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_rst_vals(input string nm);
        chk({nm, "_ctl"}, {22'd0, reset_x, slot_x_int_x, clk_rw, ax_d, r_wx, ad_oe_x,
                           req_ready, rsp_valid, irq_pending, irq_edge}, 32'b0_11111_0000);
        chk({nm, "_ad_out"}, {24'd0, ad_out}, 32'h0);
        chk({nm, "_rdata"}, {24'd0, rsp_rdata}, 32'h0);
    endtask

    // Observes n_low more negedges with reset_x low, then one with the bus released to IDLE.
    task automatic wait_rst(input string nm, input int unsigned n_low);
        for (int unsigned k = 1; k <= n_low; k++) begin
            @(negedge clk);
            chk($sformatf("%s_low%0d", nm, k), {28'd0, reset_x, slot_x_int_x, req_ready, rsp_valid}, 32'b0100);
        end
        @(negedge clk);
        chk({nm, "_release"}, {28'd0, reset_x, slot_x_int_x, req_ready, rsp_valid}, 32'b1110);
    endtask

    task automatic run_txn(input int unsigned idx, input vec_t v);
        logic [5:0] exp_ctl;
        int unsigned p, o;
        logic strobe;
        @(negedge clk);
        chk($sformatf("t%0d_ready", idx), {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        ad_in     = ~v.card;
        for (int unsigned c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            if (c <= 28) begin
                p = (c - 1) / 14;
                o = (c - 1) % 14;
                strobe = (o >= 2) && (o <= 11);
                exp_ctl = {1'b0, !strobe, p[0], !v.wr, p[0] && !v.wr, 1'b0};
            end else begin
                p = 0;
                exp_ctl = {5'b11111, c == 29};
            end
            chk($sformatf("t%0d_ctl_c%0d", idx, c),
                {26'd0, slot_x_int_x, clk_rw, ax_d, r_wx, ad_oe_x, rsp_valid}, {26'd0, exp_ctl});
            if (c <= 28 && !exp_ctl[1])
                chk($sformatf("t%0d_ad_out_c%0d", idx, c), {24'd0, ad_out},
                    {24'd0, (p == 1) ? v.wdata : v.addr});
            if (c >= 29)
                chk($sformatf("t%0d_rdata_c%0d", idx, c), {24'd0, rsp_rdata}, {24'd0, v.exp_rdata});
            ad_in = (c == 26) ? v.card : ~v.card;
        end
    endtask

    initial begin
        vecs[0] = '{wr: 1'b1, addr: 8'h12, wdata: 8'hA5, card: 8'h99, exp_rdata: 8'h00};
        vecs[1] = '{wr: 1'b0, addr: 8'h03, wdata: 8'h00, card: 8'h5C, exp_rdata: 8'h5C};
        vecs[2] = '{wr: 1'b1, addr: 8'h7F, wdata: 8'h3C, card: 8'hFF, exp_rdata: 8'h5C};
        vecs[3] = '{wr: 1'b0, addr: 8'h80, wdata: 8'h00, card: 8'hA1, exp_rdata: 8'hA1};

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; bus_reset_req = 1'b0;
        irq_x = 1'b1; req_addr = '0; req_wdata = '0; ad_in = '0;

        repeat (3) @(negedge clk);
        chk_rst_vals("por");
        reset = 1'b0;
        wait_rst("por", 16);

        for (int unsigned i = 0; i < 4; i++)
            run_txn(i, vecs[i]);

        // Back-to-back reads with req_valid held.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h21; ad_in = 8'h77;
        for (int unsigned c = 1; c <= 58; c++) begin
            @(negedge clk);
            if (c == 28) chk("b2b_slot_c28", {31'd0, slot_x_int_x}, 32'd0);
            if (c == 29) chk("b2b_c29", {29'd0, slot_x_int_x, rsp_valid, req_ready}, 32'b111);
            if (c == 30) begin
                chk("b2b_c30", {30'd0, slot_x_int_x, rsp_valid}, 32'b00);
                req_valid = 1'b0;
            end
            if (c == 58) begin
                chk("b2b_rsp2", {31'd0, rsp_valid}, 32'd1);
                chk("b2b_rdata2", {24'd0, rsp_rdata}, 32'h77);
            end
        end

        // Interrupt assertion latency and edge pulse.
        @(negedge clk);
        irq_x = 1'b0;
        @(negedge clk);
        chk("irq_n1", {30'd0, irq_pending, irq_edge}, {30'd0, !SYNC, 1'b0});
        @(negedge clk);
        chk("irq_n2", {30'd0, irq_pending, irq_edge}, {30'd0, 1'b1, SYNC});
        @(negedge clk);
        chk("irq_n3", {30'd0, irq_pending, irq_edge}, {30'd0, 2'b10});
        irq_x = 1'b1;
        repeat (3) @(negedge clk);
        chk("irq_clear", {30'd0, irq_pending, irq_edge}, 32'd0);

        // bus_reset_req wins over a simultaneous request.
        @(negedge clk);
        bus_reset_req = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h55;
        @(negedge clk);
        chk("brst_n1", {28'd0, reset_x, slot_x_int_x, req_ready, rsp_valid}, 32'b0100);
        bus_reset_req = 1'b0; req_valid = 1'b0;
        wait_rst("brst", 15);

        // Reset during D_STROBE of a read.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h44; ad_in = 8'h11;
        for (int unsigned c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
        end
        chk("mid_in_dstrobe", {30'd0, ax_d, clk_rw}, 32'b10);
        reset = 1'b1;
        @(negedge clk);
        chk_rst_vals("mid");
        reset = 1'b0;
        wait_rst("mid", 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/monitor_bus_master.md
# monitor_bus_master

Monitor-side initiator for the BKM-68X option-slot bus: drives the multiplexed 8-bit address/data bus, strobes, and card select, and services the card's interrupt line. It turns single-byte read/write requests from a host-side controller into complete slot bus transactions. It also generates the bus reset pulse. Main use is driving a `monitor_interface` card in bench and loopback builds; all slot pins are in connector polarity.

## Interface
- `SETUP_CYCLES`, 2: cycles from bus drive to strobe low (≥1)
- `STROBE_CYCLES`, 10: cycles `clk_rw` held low (≥1)
- `HOLD_CYCLES`, 2: cycles after strobe high before the next phase (≥1)
- `RESET_CYCLES`, 16: bus `reset_x` low time after `reset` drops or a bus reset request (≥1)

- `clk_50mhz_in` in 1: system clock
- `reset` in 1: synchronous, active-high
- `req_valid` in 1: request present
- `req_ready` out 1: request accepted when `req_valid & req_ready`
- `req_write` in 1: 1 = write, 0 = read
- `req_addr` in 8: register address
- `req_wdata` in 8: write data
- `rsp_valid` out 1: one-cycle pulse when the transaction completes
- `rsp_rdata` out 8: read data, valid with `rsp_valid`; holds its value until the next read completes
- `bus_reset_req` in 1: request a bus reset pulse
- `irq_pending` out 1: card interrupt asserted (level)
- `irq_edge` out 1: one-cycle pulse on interrupt assertion
- `slot_x_int_x` out 1: card select, active-low
- `clk_rw` out 1: strobe, active-low
- `ax_d` out 1: 0 = address phase, 1 = data phase
- `r_wx` out 1: 1 = read, 0 = write
- `reset_x` out 1: bus reset, active-low
- `ad_out` out 8: bus drive value
- `ad_oe_x` out 1: bus output enable, active-low
- `ad_in` in 8: bus sample
- `irq_x` in 1: card interrupt, active-low, asynchronous

## Operation
- States: RST, IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD.
- Reset values while `reset` is high:
  - `reset_x`=0; `slot_x_int_x`, `clk_rw`, `ax_d`, `r_wx`, `ad_oe_x` all =1.
  - `ad_out`=0, `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `irq_pending`=0, `irq_edge`=0.
  - State = RST.
- RST: holds `reset_x`=0 for `RESET_CYCLES` cycles, then goes to IDLE with `reset_x`=1.
- IDLE:
  - `req_ready`=1.
  - `bus_reset_req` has priority over `req_valid` in the same cycle: it enters RST and the request is not accepted.
  - On accept, latch `req_write`, `req_addr`, `req_wdata`, then go to A_SETUP.
- A_* states: `ax_d`=0, `ad_out`=addr, `ad_oe_x`=0.
- D_* states: `ax_d`=1.
  - Write: `ad_out`=wdata, `ad_oe_x`=0.
  - Read: `ad_oe_x`=1.
- `slot_x_int_x`=0 and `r_wx`=~write in every A_* and D_* state; both are 1 in IDLE and RST.
- `clk_rw`=0 only in A_STROBE and D_STROBE.
- Read data: `ad_in` is sampled on the last D_STROBE cycle into `rsp_rdata`.
- After D_HOLD, return to IDLE with `rsp_valid`=1 for that first IDLE cycle. A new request may be accepted in that same cycle.
- `bus_reset_req` is ignored outside IDLE.
- If `reset` is asserted mid-transaction: reset values apply at the next edge and no `rsp_valid` is generated.
- `irq_pending`/`irq_edge` operate in every state, including RST.

## Timing
- Accept at cycle 0; A_SETUP starts at cycle 1.
- Each phase is `SETUP_CYCLES` + `STROBE_CYCLES` + `HOLD_CYCLES` cycles long.
- `rsp_valid` fires at cycle 2·(S+T+H)+1, which is cycle 29 with defaults.
- Minimum request-to-request spacing is 2·(S+T+H)+1 cycles.
- All bus outputs are registered; no combinational path from `ad_in` or `irq_x` to outputs.
- `req_ready` is registered-state decoded.

## Configuration
- `MONBUS_IRQ_SYNC_EN` defined:
  - `irq_x` passes through a 2-flop synchronizer; `irq_pending` = ~synced value, 2-cycle latency.
  - `irq_edge` pulses one cycle on each 1→0 transition of the synced value.
- Not defined:
  - `irq_pending` = ~`irq_x` registered once, 1-cycle latency.
  - `irq_edge` is tied to 0.

## Test plan
- Reset release with defaults → `reset_x` low for 16 cycles after `reset` drops, then `req_ready`=1 and all other bus outputs idle-high.
- Write addr 0x12 data 0xA5 → `ax_d`=0/`ad_out`=0x12, then `ax_d`=1/`ad_out`=0xA5.
  - `clk_rw` low 10 cycles in each phase; `r_wx`=0 throughout.
  - `rsp_valid` at cycle 29.
- Read addr 0x03 with the card driving 0x5C → `ad_oe_x`=1 in the data phase; `rsp_rdata`=0x5C with `rsp_valid` at cycle 29.
- Back-to-back reads with `req_valid` held → second accept coincides with the first `rsp_valid`; `slot_x_int_x` deasserts for exactly one cycle between transactions.
- `reset` asserted mid-D_STROBE → all outputs return to reset values next cycle; no `rsp_valid`; `reset_x` pulse runs again.
- `irq_x` driven low → `irq_pending`=1 after 2 cycles with one `irq_edge` pulse when the macro is defined; after 1 cycle with `irq_edge`=0 when it is not. `bus_reset_req` and `req_valid` together in IDLE → RST entered, request not accepted.
